// File: rtl/wb_stage.sv
// MEM/WB pipeline register and register-file write-back selector.
// Optional forwarding taps are enabled by defining WB_FWD_EN.
module wb_stage #(
  parameter int REG_WIDTH     = 8,
  parameter int REG_DIR_WIDTH = 3,
  parameter int RET_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [REG_WIDTH-1:0]     alu_result,
  input  logic [REG_WIDTH-1:0]     mem_data,
  input  logic [REG_DIR_WIDTH-1:0] dest,
  input  logic                     reg_write_in,
  input  logic                     mem_to_reg,
`ifdef WB_FWD_EN
  output logic                     fwd_valid,
  output logic [REG_DIR_WIDTH-1:0] fwd_dest,
  output logic [REG_WIDTH-1:0]     fwd_data,
`endif
  output logic [REG_DIR_WIDTH-1:0] writer,
  output logic [REG_WIDTH-1:0]     writedata,
  output logic                     RegWrite,
  output logic                     wb_valid,
  output logic [RET_WIDTH-1:0]     retired
);

  typedef enum logic [1:0] {
    M_BUB,
    M_HOLD,
    M_LOAD
  } mode_t;

  mode_t                    mode;
  logic                     valid_q;
  logic                     fresh_q;
  logic                     rw_q;
  logic                     valid_n;
  logic                     fresh_n;
  logic                     rw_n;
  logic                     regwr_n;
  logic [REG_DIR_WIDTH-1:0] writer_n;
  logic [REG_WIDTH-1:0]     wdata_n;
  logic [RET_WIDTH-1:0]     retired_n;

  // Resolve flush > stall > load; an invalid load is a bubble.
  always_comb begin
    mode = M_LOAD;
    if (flush)
      mode = M_BUB;
    else if (stall)
      mode = M_HOLD;
    else if (!in_valid)
      mode = M_BUB;
  end

  // Next stage contents, write decode and retire count.
  always_comb begin
    valid_n  = valid_q;
    fresh_n  = 1'b0;
    rw_n     = rw_q;
    writer_n = writer;
    wdata_n  = writedata;
    unique case (mode)
      M_BUB: begin
        valid_n  = 1'b0;
        rw_n     = 1'b0;
        writer_n = '0;
        wdata_n  = '0;
      end
      M_HOLD: begin
        fresh_n = 1'b0;
      end
      M_LOAD: begin
        valid_n  = 1'b1;
        fresh_n  = 1'b1;
        rw_n     = reg_write_in;
        writer_n = dest;
        wdata_n  = mem_to_reg ? mem_data
                              : alu_result;
      end
      default: begin
        valid_n = 1'b0;
      end
    endcase
    regwr_n = valid_n & fresh_n
            & rw_n & (|writer_n);
    retired_n = retired;
    if (valid_n && fresh_n)
      retired_n = retired + RET_WIDTH'(1);
  end

  // Stage register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      fresh_q   <= 1'b0;
      rw_q      <= 1'b0;
      writer    <= '0;
      writedata <= '0;
      RegWrite  <= 1'b0;
      retired   <= '0;
    end else begin
      valid_q   <= valid_n;
      fresh_q   <= fresh_n;
      rw_q      <= rw_n;
      writer    <= writer_n;
      writedata <= wdata_n;
      RegWrite  <= regwr_n;
      retired   <= retired_n;
    end
  end

  assign wb_valid = valid_q;

`ifdef WB_FWD_EN
  assign fwd_valid = RegWrite;
  assign fwd_dest  = writer;
  assign fwd_data  = writedata;
`endif

  // Register 0 is never written.
  a_no_r0: assert property (
    @(posedge clk) RegWrite |-> (writer != '0));

  // Writes only come from a fresh valid slot.
  a_wr_fresh: assert property (
    @(posedge clk) RegWrite |-> (valid_q && fresh_q));

  // Empty slot carries no data.
  a_bub_zero: assert property (
    @(posedge clk) !valid_q |->
      (writer == '0 && writedata == '0));

endmodule

// File: tb/tb_wb_stage.sv
// Directed vector bench for wb_stage.
// Table of single-cycle vectors plus a retire-counter wrap sequence.
module tb_wb_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       stall;
  logic       flush;
  logic [7:0] alu_result;
  logic [7:0] mem_data;
  logic [2:0] dest;
  logic       reg_write_in;
  logic       mem_to_reg;
  logic [2:0] writer;
  logic [7:0] writedata;
  logic       RegWrite;
  logic       wb_valid;
  logic [15:0] retired;
`ifdef WB_FWD_EN
  logic       fwd_valid;
  logic [2:0] fwd_dest;
  logic [7:0] fwd_data;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .stall        (stall),
    .flush        (flush),
    .alu_result   (alu_result),
    .mem_data     (mem_data),
    .dest         (dest),
    .reg_write_in (reg_write_in),
    .mem_to_reg   (mem_to_reg),
`ifdef WB_FWD_EN
    .fwd_valid    (fwd_valid),
    .fwd_dest     (fwd_dest),
    .fwd_data     (fwd_data),
`endif
    .writer       (writer),
    .writedata    (writedata),
    .RegWrite     (RegWrite),
    .wb_valid     (wb_valid),
    .retired      (retired)
  );

  typedef struct {
    logic        r;
    logic        iv;
    logic        st;
    logic        fl;
    logic [7:0]  alu;
    logic [7:0]  mem;
    logic [2:0]  dst;
    logic        rw;
    logic        m2r;
    logic [2:0]  e_wr;
    logic [7:0]  e_wd;
    logic        e_rw;
    logic        e_v;
    logic [15:0] e_ret;
  } vec_t;

  vec_t vq[$];

  task automatic add(
    input logic r, iv, st, fl,
    input logic [7:0] alu, mem,
    input logic [2:0] dst,
    input logic rw, m2r,
    input logic [2:0] e_wr,
    input logic [7:0] e_wd,
    input logic e_rw, e_v,
    input logic [15:0] e_ret);
    vec_t v;
    v.r = r; v.iv = iv; v.st = st; v.fl = fl;
    v.alu = alu; v.mem = mem; v.dst = dst;
    v.rw = rw; v.m2r = m2r;
    v.e_wr = e_wr; v.e_wd = e_wd;
    v.e_rw = e_rw; v.e_v = e_v;
    v.e_ret = e_ret;
    vq.push_back(v);
  endtask

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic drive(
    input logic r, iv, st, fl,
    input logic [7:0] alu, mem,
    input logic [2:0] dst,
    input logic rw, m2r);
    rst = r; in_valid = iv;
    stall = st; flush = fl;
    alu_result = alu; mem_data = mem;
    dest = dst; reg_write_in = rw;
    mem_to_reg = m2r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(
    input string tag,
    input logic [2:0] e_wr,
    input logic [7:0] e_wd,
    input logic e_rw, e_v,
    input logic [15:0] e_ret);
    chk({tag, ".writer"}, 32'(writer), 32'(e_wr));
    chk({tag, ".wdata"}, 32'(writedata), 32'(e_wd));
    chk({tag, ".RegWrite"}, 32'(RegWrite), 32'(e_rw));
    chk({tag, ".wb_valid"}, 32'(wb_valid), 32'(e_v));
    chk({tag, ".retired"}, 32'(retired), 32'(e_ret));
`ifdef WB_FWD_EN
    chk({tag, ".fwd_v"}, 32'(fwd_valid), 32'(e_rw));
    chk({tag, ".fwd_d"}, 32'(fwd_dest), 32'(e_wr));
    chk({tag, ".fwd_x"}, 32'(fwd_data), 32'(e_wd));
`endif
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00,
          3'd0, 1'b0, 1'b0);

    //   r  iv st fl alu    mem    d  rw m2r | wr wd    RW v ret
    add(1, 1, 0, 0, 8'hFF, 8'hA5, 7, 1, 1,  0, 8'h00, 0, 0, 0);
    add(0, 1, 0, 0, 8'h5A, 8'h11, 3, 1, 0,  3, 8'h5A, 1, 1, 1);
    add(0, 1, 0, 0, 8'h22, 8'hC3, 0, 1, 1,  0, 8'hC3, 0, 1, 2);
    add(0, 1, 0, 0, 8'h77, 8'h00, 5, 1, 0,  5, 8'h77, 1, 1, 3);
    add(0, 1, 1, 0, 8'hEE, 8'hDD, 2, 1, 0,  5, 8'h77, 0, 1, 3);
    add(0, 1, 1, 0, 8'hEE, 8'hDD, 2, 1, 1,  5, 8'h77, 0, 1, 3);
    add(0, 0, 1, 0, 8'h01, 8'h02, 6, 0, 0,  5, 8'h77, 0, 1, 3);
    add(0, 1, 1, 1, 8'h99, 8'h98, 4, 1, 0,  0, 8'h00, 0, 0, 3);
    add(0, 0, 0, 0, 8'hAB, 8'hCD, 6, 1, 0,  0, 8'h00, 0, 0, 3);
    add(0, 1, 0, 0, 8'h3C, 8'h4D, 6, 0, 0,  6, 8'h3C, 0, 1, 4);
    add(0, 1, 0, 0, 8'h12, 8'h81, 1, 1, 1,  1, 8'h81, 1, 1, 5);
    add(0, 1, 1, 0, 8'h55, 8'h66, 7, 1, 0,  1, 8'h81, 0, 1, 5);
    add(1, 1, 1, 0, 8'h55, 8'h66, 7, 1, 0,  0, 8'h00, 0, 0, 0);
    add(0, 1, 0, 0, 8'h10, 8'h20, 2, 1, 0,  2, 8'h10, 1, 1, 1);
    add(0, 1, 0, 1, 8'h44, 8'h45, 3, 1, 0,  0, 8'h00, 0, 0, 1);
    add(0, 1, 0, 0, 8'h61, 8'h62, 7, 1, 0,  7, 8'h61, 1, 1, 2);
    add(1, 1, 0, 1, 8'h61, 8'h62, 7, 1, 0,  0, 8'h00, 0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].r, vq[i].iv, vq[i].st,
            vq[i].fl, vq[i].alu, vq[i].mem,
            vq[i].dst, vq[i].rw, vq[i].m2r);
      step();
      chk_out($sformatf("v%0d", i),
              vq[i].e_wr, vq[i].e_wd,
              vq[i].e_rw, vq[i].e_v,
              vq[i].e_ret);
      @(negedge clk);
    end

    // Counter wrap: 65535 loads then one more.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00,
          3'd0, 1'b0, 1'b0);
    step();
    chk("wrap.rst", 32'(retired), 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h3A, 8'h00,
          3'd4, 1'b1, 1'b0);
    for (int i = 0; i < 65535; i++)
      @(posedge clk);
    #1;
    chk("wrap.max", 32'(retired), 32'hFFFF);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h3B, 8'h00,
          3'd4, 1'b1, 1'b0);
    step();
    chk_out("wrap", 3'd4, 8'h3B, 1'b1, 1'b1,
            16'h0000);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00,
          3'd0, 1'b0, 1'b0);
    step();
    chk_out("wrap.stall", 3'd4, 8'h3B, 1'b0,
            1'b1, 16'h0000);

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
